sobel_line_ctrl: RTL
====================

Name: sobel_line_ctrl

Overview:
Line-buffer controller that turns a raster pixel stream into vertically aligned 3-row column triples for the sobel window stage (feeds its d0_i/d1_i/d2_i/done_i). It primes two internal line buffers and tracks row/column position. It emits one triple per accepted pixel from row 2 onward, and sequences frames with start/busy/frame-done handshakes.

Parameters:
ROWS, 5, frame height in pixels; legal range >= 3
COLS, 6, frame width in pixels; legal range >= 3
DW, 8, pixel width in bits

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
start_i  in  1  frame start request; honoured only in IDLE
pix_i  in  DW  input pixel, raster order
pix_vld_i  in  1  pix_i valid
pix_rdy_o  out  1  controller accepts pixels; a pixel is accepted when pix_vld_i & pix_rdy_o
d0_o  out  DW  pixel from row r-2, same column
d1_o  out  DW  pixel from row r-1, same column
d2_o  out  DW  pixel from current row r
done_o  out  1  d0_o..d2_o valid this cycle; drives the window stage done_i
busy_o  out  1  high in FILL, RUN, DONE
frame_done_o  out  1  one-cycle pulse, frame complete

Behaviour:
- Reset (rst=0, async): state=IDLE; col_cnt=0; row_cnt=0; d0_o/d1_o/d2_o=0; done_o=0; pix_rdy_o=0; busy_o=0; frame_done_o=0. Line buffer contents are don't-care after reset.
- Counter widths: col_cnt is $clog2(COLS) bits; row_cnt is $clog2(ROWS) bits.
- Each accepted pixel advances col_cnt. When col_cnt=COLS-1, col_cnt wraps to 0 and row_cnt increments.
- If pix_vld_i is low, counters, buffers and state hold, and done_o=0 next cycle.
- Line buffers: A holds row r-1 and B holds row r-2, each COLS entries deep. On an accepted pixel at column c:
  - read a=A[c] and b=B[c] (combinational read);
  - write B[c]<=a and A[c]<=pix_i.
- State machine:
  - IDLE: pix_rdy_o=0. start_i=1 -> FILL, with counters cleared.
  - FILL: pix_rdy_o=1, done_o=0. Accepted pixels are stored only. Accepting the pixel at row 1, col COLS-1 -> RUN.
  - RUN: pix_rdy_o=1. Each accepted pixel registers d0_o<=b, d1_o<=a, d2_o<=pix_i, done_o<=1 (latency 1 cycle). Accepting the pixel at row ROWS-1, col COLS-1 -> DONE.
  - DONE: pix_rdy_o=0. frame_done_o=1 for exactly this cycle, coinciding with the final done_o. Next cycle -> IDLE.
- Outputs per frame: exactly (ROWS-2)*COLS triples, with done_o high once per triple.
- Output hold: d*_o hold their last value when done_o=0.
- start_i in FILL, RUN or DONE: ignored, no restart.
- start_i in the same cycle DONE->IDLE: ignored. The earliest new start is the first IDLE cycle.
- Reset mid-frame: immediate return to IDLE. The partial frame is discarded and no frame_done_o is issued.
- Pixel presented with pix_rdy_o=0: not accepted and not counted.

Decomposition:
- Header sobel_defs.vh holds:
  - state encodings IDLE=2'd0, FILL=2'd1, RUN=2'd2, DONE=2'd3;
  - default DW.
- Sub-module sobel_line_buf: one COLS x DW register array with combinational read, synchronous write enable and write address.
  - Instantiated twice (A, B).
  - No reset on the array.
- Top level holds the FSM, counters and output registers.

Test Plan:
- Basic frame (ROWS=5, COLS=6): start_i pulse, then pixels 1..30 with pix_vld_i=1 every cycle.
  - First done_o one cycle after accepting pixel 13, with d0_o=1, d1_o=7, d2_o=13.
  - Last triple is 18/24/30.
  - Exactly 18 done_o pulses.
  - frame_done_o is high in the same cycle as the last done_o.
  - pix_rdy_o is low afterwards.
- Valid gaps: same frame with pix_vld_i low every 3rd cycle -> identical triple sequence; done_o=0 in each cycle after a gap.
- Ignored start: pulse start_i while in RUN (after pixel 15) -> no counter reset; output sequence unchanged from the basic frame.
- Mid-frame reset: assert rst=0 after pixel 20, release, start a new frame with pixels 101..130.
  - First triple is 101/107/113.
  - No frame_done_o before the new frame completes.
- Back-to-back frames: start_i on the first IDLE cycle after frame_done_o; second frame pixels 31..60 -> first triple 31/37/43; no stale row data from frame 1.
- Minimum size (ROWS=3, COLS=3), pixels 1..9 -> exactly 3 triples, 1/4/7, 2/5/8, 3/6/9; frame_done_o coincides with 3/6/9.

Source files
------------

// File: rtl/sobel_line_ctrl_pkg.sv
// Shared types and defaults for the sobel line-buffer controller.
// The state encoding is fixed so debug probes and checkers can decode state_o directly.
package sobel_line_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_DW = 8;

endpackage

// File: rtl/sobel_line_buf.sv
// One row of pixel storage: COLS x DW registers, combinational read, synchronous write.
// The array is intentionally not reset; a row is always written before it is read out.
module sobel_line_buf #(
  parameter int COLS = 6,
  parameter int DW   = 8,
  parameter int AW   = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [COLS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_line_ctrl.sv
// Turns a raster pixel stream into vertically aligned 3-row column triples.
// Two line buffers hold rows r-1 (A) and r-2 (B); triples are emitted from row 2 onward.
module sobel_line_ctrl
  import sobel_line_ctrl_pkg::*;
#(
  parameter int ROWS = 5,
  parameter int COLS = 6,
  parameter int DW   = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [DW-1:0] pix_i,
  input  logic          pix_vld_i,
  output logic          pix_rdy_o,
  output logic [DW-1:0] d0_o,
  output logic [DW-1:0] d1_o,
  output logic [DW-1:0] d2_o,
  output logic          done_o,
  output logic          busy_o,
  output logic          frame_done_o,
  output state_t        state_o
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  state_t        state, state_nxt;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [DW-1:0] a, b;
  logic          accept;
  logic          col_last;

  // Handshake: a pixel transfers on a rising edge where pix_vld_i & pix_rdy_o;
  // pix_rdy_o depends only on state, never combinationally on pix_vld_i.
  assign accept   = pix_vld_i & pix_rdy_o;
  assign col_last = (col_cnt == CW'(COLS - 1));

  sobel_line_buf #(.COLS(COLS), .DW(DW)) u_buf_a (
    .clk   (clk),
    .we    (accept),
    .addr  (col_cnt),
    .wdata (pix_i),
    .rdata (a)
  );

  sobel_line_buf #(.COLS(COLS), .DW(DW)) u_buf_b (
    .clk   (clk),
    .we    (accept),
    .addr  (col_cnt),
    .wdata (a),
    .rdata (b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    pix_rdy_o    = 1'b0;
    busy_o       = 1'b1;
    frame_done_o = 1'b0;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_nxt = FILL;
      end
      FILL: begin
        pix_rdy_o = 1'b1;
        if (accept && col_last && row_cnt == RW'(1)) state_nxt = RUN;
      end
      RUN: begin
        pix_rdy_o = 1'b1;
        if (accept && col_last && row_cnt == RW'(ROWS - 1)) state_nxt = DONE;
      end
      DONE: begin
        frame_done_o = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign state_o = state;

  // Position counters are cleared by the start that leaves IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (state == IDLE && start_i) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + RW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d0_o   <= '0;
      d1_o   <= '0;
      d2_o   <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= accept && (state == RUN);
      if (accept && state == RUN) begin
        d0_o <= b;
        d1_o <= a;
        d2_o <= pix_i;
      end
    end
  end

endmodule
